// File: rtl/rim_path_pack.sv
// Collects a 15-beat monotone grid path (down/right moves from (0,0)) and packs it
// into a 14-bit move code with status, behind a single-entry valid/ready output.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for beat 0 of a new path
// COLLECT | beats 1..14 being checked and packed; in_valid low ends as SHORT
module rim_path_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  in_row,
    input  logic [2:0]  in_col,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [13:0] out_dirs,
    output logic [1:0]  out_err,
    output logic        overrun,
    output logic [7:0]  ok_cnt
);

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_BAD_START = 2'd1;
    localparam logic [1:0] ERR_BAD_STEP  = 2'd2;
    localparam logic [1:0] ERR_SHORT     = 2'd3;
    localparam logic [3:0] LAST_CNT      = 4'd14;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  beat_cnt, beat_cnt_nxt;
    logic [2:0]  prev_row, prev_row_nxt;
    logic [2:0]  prev_col, prev_col_nxt;
    logic [1:0]  err, err_nxt;
    logic [13:0] dirs, dirs_nxt;
    logic        fin;
    logic [1:0]  fin_err;
    logic [13:0] fin_dirs;
    logic        step_down, step_right;
    logic [3:0]  dir_idx;
    logic        consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
            prev_row <= 3'd0;
            prev_col <= 3'd0;
            err      <= ERR_OK;
            dirs     <= 14'h0000;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            prev_row <= prev_row_nxt;
            prev_col <= prev_col_nxt;
            err      <= err_nxt;
            dirs     <= dirs_nxt;
        end
    end

    // Widened compare so a 7 -> 0 wrap never looks like a legal +1 step
    always_comb begin
        step_down  = (({1'b0, prev_row} + 4'd1) == {1'b0, in_row}) && (in_col == prev_col);
        step_right = (({1'b0, prev_col} + 4'd1) == {1'b0, in_col}) && (in_row == prev_row);
        dir_idx    = beat_cnt - 4'd1;
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        prev_row_nxt = prev_row;
        prev_col_nxt = prev_col;
        err_nxt      = err;
        dirs_nxt     = dirs;
        fin          = 1'b0;
        fin_err      = err;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt    = COLLECT;
                    beat_cnt_nxt = 4'd1;
                    prev_row_nxt = in_row;
                    prev_col_nxt = in_col;
                    dirs_nxt     = 14'h0000;
                    err_nxt      = ((in_row != 3'd0) || (in_col != 3'd0)) ? ERR_BAD_START : ERR_OK;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                    prev_row_nxt = in_row;
                    prev_col_nxt = in_col;
                    if (step_down)
                        dirs_nxt = dirs | (14'd1 << dir_idx);
                    if (!step_down && !step_right && (err == ERR_OK))
                        err_nxt = ERR_BAD_STEP;
                    if (beat_cnt == LAST_CNT) begin
                        fin          = 1'b1;
                        fin_err      = err_nxt;
                        state_nxt    = IDLE;
                        beat_cnt_nxt = 4'd0;
                    end
                end else begin
                    fin          = 1'b1;
                    fin_err      = (err == ERR_OK) ? ERR_SHORT : err;
                    state_nxt    = IDLE;
                    beat_cnt_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        fin_dirs = (fin_err == ERR_OK) ? dirs_nxt : 14'h0000;
    end

    assign consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dirs  <= 14'h0000;
            out_err   <= ERR_OK;
            overrun   <= 1'b0;
            ok_cnt    <= 8'd0;
        end else begin
            if (fin && (!out_valid || consume)) begin
                out_valid <= 1'b1;
                out_dirs  <= fin_dirs;
                out_err   <= fin_err;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            // A finished path with nowhere to go is lost; remember that it happened
            if (fin && out_valid && !consume)
                overrun <= 1'b1;
            if (consume && (out_err == ERR_OK) && (ok_cnt != 8'hFF))
                ok_cnt <= ok_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rim_path_pack.sv
// Directed bench for rim_path_pack: legal, malformed, short, overrun, reset and
// saturation cases, with expected values worked out by hand.
module tb_rim_path_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_row;
    logic [2:0]  in_col;
    logic        out_ready;
    logic        out_valid;
    logic [13:0] out_dirs;
    logic [1:0]  out_err;
    logic        overrun;
    logic [7:0]  ok_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_ok = 0;

    rim_path_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_col    (in_col),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_dirs  (out_dirs),
        .out_err   (out_err),
        .overrun   (overrun),
        .ok_cnt    (ok_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [2:0] r, input logic [2:0] c);
        in_valid = 1'b1;
        in_row   = r;
        in_col   = c;
        tick();
    endtask

    // Bit i of d chooses move i: 1 = down, 0 = right
    task automatic send_path(input logic [2:0] r0, input logic [2:0] c0,
                             input logic [13:0] d, input int nbeats);
        logic [2:0] r;
        logic [2:0] c;
        r = r0;
        c = c0;
        send_beat(r, c);
        for (int i = 0; i < nbeats - 1; i++) begin
            if (d[i]) r = r + 3'd1;
            else      c = c + 3'd1;
            send_beat(r, c);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        exp_ok   = 0;
    endtask

    task automatic note_ok();
        exp_ok = (exp_ok == 255) ? 255 : exp_ok + 1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_row    = 3'd0;
        in_col    = 3'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_dirs", 32'(out_dirs), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_okcnt", 32'(ok_cnt), 32'd0);

        // 7 right then 7 down
        send_path(3'd0, 3'd0, 14'h3F80, 15);
        chk("rd_valid", 32'(out_valid), 32'd1);
        chk("rd_dirs", 32'(out_dirs), 32'h3F80);
        chk("rd_err", 32'(out_err), 32'd0);
        idle(1);
        note_ok();
        chk("rd_okcnt", 32'(ok_cnt), 32'(exp_ok));
        chk("rd_drop", 32'(out_valid), 32'd0);

        // alternating, then back-to-back second path
        send_path(3'd0, 3'd0, 14'h1555, 15);
        chk("alt_valid", 32'(out_valid), 32'd1);
        chk("alt_dirs", 32'(out_dirs), 32'h1555);
        chk("alt_err", 32'(out_err), 32'd0);
        send_path(3'd0, 3'd0, 14'h2AAA, 15);
        note_ok();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_dirs", 32'(out_dirs), 32'h2AAA);
        chk("b2b_okcnt", 32'(ok_cnt), 32'(exp_ok));
        idle(1);
        note_ok();

        // bad start, with a later wrap step that must not override it
        send_path(3'd0, 3'd1, 14'h0000, 15);
        chk("bstart_valid", 32'(out_valid), 32'd1);
        chk("bstart_err", 32'(out_err), 32'd1);
        chk("bstart_dirs", 32'(out_dirs), 32'd0);
        idle(1);

        // diagonal step
        send_beat(3'd0, 3'd0);
        repeat (14) send_beat(3'd1, 3'd1);
        chk("diag_err", 32'(out_err), 32'd2);
        chk("diag_dirs", 32'(out_dirs), 32'd0);
        idle(1);

        // short path: 10 beats then drop
        send_path(3'd0, 3'd0, 14'h3F80, 10);
        in_valid = 1'b0;
        chk("short_early", 32'(out_valid), 32'd0);
        tick();
        chk("short_valid", 32'(out_valid), 32'd1);
        chk("short_err", 32'(out_err), 32'd3);
        chk("short_dirs", 32'(out_dirs), 32'd0);
        idle(1);

        // column wrap 7 -> 0
        send_path(3'd0, 3'd0, 14'h0000, 15);
        chk("wrap_err", 32'(out_err), 32'd2);
        chk("wrap_dirs", 32'(out_dirs), 32'd0);
        idle(1);
        chk("err_okcnt", 32'(ok_cnt), 32'(exp_ok));

        // overrun: two paths while the consumer stalls
        do_reset();
        out_ready = 1'b0;
        send_path(3'd0, 3'd0, 14'h3F80, 15);
        chk("ovr_first", 32'(out_dirs), 32'h3F80);
        send_path(3'd0, 3'd0, 14'h1555, 15);
        chk("ovr_valid", 32'(out_valid), 32'd1);
        chk("ovr_held", 32'(out_dirs), 32'h3F80);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_okcnt", 32'(ok_cnt), 32'd0);
        out_ready = 1'b1;
        idle(1);
        note_ok();
        chk("ovr_drain", 32'(out_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_okcnt2", 32'(ok_cnt), 32'(exp_ok));

        // reset mid-path discards the partial path
        do_reset();
        chk("rst2_overrun", 32'(overrun), 32'd0);
        send_path(3'd0, 3'd0, 14'h1555, 9);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        idle(3);
        chk("midrst_none", 32'(out_valid), 32'd0);
        send_path(3'd0, 3'd0, 14'h3F80, 15);
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_dirs", 32'(out_dirs), 32'h3F80);
        chk("postrst_err", 32'(out_err), 32'd0);
        idle(1);
        note_ok();

        // saturation of ok_cnt
        for (int i = 0; i < 256; i++) begin
            send_path(3'd0, 3'd0, 14'h1555, 15);
            if (i > 0) note_ok();
        end
        idle(1);
        note_ok();
        chk("sat_okcnt", 32'(ok_cnt), 32'(exp_ok));
        chk("sat_value", 32'(ok_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rim_path_pack.md
RIM_PATH_PACK -- requirements
Module: rim_path_pack

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-003 in_valid  input  1  high while a path coordinate beat is present; one beat per cycle.
REQ-004 in_row  input  3  row of the current path cell (0..7).
REQ-005 in_col  input  3  column of the current path cell (0..7).
REQ-006 out_ready  input  1  consumer accepts the pending result when high with out_valid.
REQ-007 out_valid  output  1  a packed path result is pending.
REQ-008 out_dirs  output  14  move code; bit i = move i; 1 = down (row+1), 0 = right (col+1).
REQ-009 out_err  output  2  result status: 0 OK, 1 BAD_START, 2 BAD_STEP, 3 SHORT.
REQ-010 overrun  output  1  sticky flag: a result was dropped because the output was still pending.
REQ-011 ok_cnt  output  8  number of OK results accepted, saturating.

Function
REQ-012 The path shall be 15 beats: cell (0,0), then 14 cells, each one move down or right from the previous cell.
REQ-013 The collector FSM shall have exactly two states, IDLE and COLLECT.
- IDLE with in_valid high: capture beat 0 and go to COLLECT with beat count 1.
REQ-014 In COLLECT, each in_valid-high beat shall increment the beat count.
- Beat 15 shall finish the path and return to IDLE.
REQ-015 Beat 0 not equal to (0,0) shall record BAD_START.
REQ-016 For beat k (k = 1..14), a step of (row+1, col same) shall set dir bit k-1 to 1.
- A step of (row same, col+1) shall set dir bit k-1 to 0.
- Any other step shall record BAD_STEP.
- A carry out of the 3-bit field (7 to 0) shall record BAD_STEP.
REQ-017 Only the first recorded error shall be kept for a path.
- Beats after an error shall still be counted until the path finishes.
REQ-018 In COLLECT, in_valid low before beat 15 shall finish the path with SHORT, unless an earlier error was already recorded.
REQ-019 A finished path shall present its result on the cycle after its last beat, or after the in_valid drop for SHORT.
- out_valid shall be high and out_err set to the final status.
REQ-020 out_dirs shall carry the packed code when out_err = 0 and shall be 14'h0000 otherwise.
REQ-021 out_valid, out_dirs and out_err shall stay stable while out_valid is high and out_ready is low.
REQ-022 The result shall be consumed on a cycle with out_valid and out_ready both high.
- out_valid shall drop the next cycle unless a new result loads in that same cycle.
REQ-023 When a new result and a consume happen in the same cycle, the new result shall load and out_valid shall stay high.
REQ-024 When a new result finishes while the output is pending and not consumed, the new result shall be dropped, the output shall be unchanged, and overrun shall be set.
REQ-025 overrun shall remain set until reset.
REQ-026 ok_cnt shall increment on each consume with out_err = 0.
- ok_cnt shall saturate at 255.
REQ-027 in_valid high on the cycle after beat 15 shall start a new path (beat 0).
REQ-028 Collection shall continue while the output is pending.
- Back-to-back paths with no idle cycle between them shall be supported.
REQ-029 Latency from the last input beat to out_valid shall be exactly 1 cycle.

Reset
REQ-030 While rst is high at a rising edge, the FSM shall enter IDLE and the beat count, error and dir registers shall clear.
- out_valid = 0, out_dirs = 0, out_err = 0, overrun = 0, ok_cnt = 0.
REQ-031 Reset shall take priority over every other input.
- A path in progress when reset asserts shall be discarded and produce no result.
REQ-032 The first in_valid beat after rst deasserts shall be treated as beat 0.

Verification
REQ-033 Path (0,0) then 7 steps right then 7 steps down, out_ready=1 -> 1 cycle after beat 15: out_valid=1, out_dirs=14'h3F80, out_err=0; ok_cnt=1 after consume.
REQ-034 Alternating path starting with down (bit i = 1 for even i) -> out_dirs=14'h1555, out_err=0; a back-to-back second path with no idle cycle -> second result on the cycle after its beat 15.
REQ-035 Beat 0=(0,1) -> out_err=1, out_dirs=0; second beat (0,0)->(1,1) step -> out_err=2; a later BAD_STEP in the BAD_START path leaves out_err=1.
REQ-036 10 valid beats, then in_valid low -> out_valid=1 with out_err=3 on the cycle after the drop; (0,0)->(0,7) then step to col 0 -> out_err=2.
REQ-037 out_ready=0, two complete paths -> first result held unchanged, overrun=1, ok_cnt=0; then out_ready=1 -> first result consumed, out_valid=0 next cycle, overrun stays 1.
REQ-038 rst pulse after beat 8 -> no result for that path; the next 15-beat legal path produces a correct result; 256 OK consumes -> ok_cnt=255.
